// File: rtl/xadc_pkg.sv
// Shared definitions for the XADC sampling sequencer: FSM encoding,
// control word bit positions and data word layout.
package xadc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_STAT  = 3'd4
    } state_t;

    localparam int CTRL_START  = 0;
    localparam int CTRL_CONT   = 1;
    localparam int CTRL_AVG_LO = 2;
    localparam int CTRL_AVG_HI = 3;
    localparam int CTRL_ACK    = 4;
    localparam int CTRL_THR_LO = 5;
    localparam int CTRL_THR_HI = 8;

    localparam int DATA_AVG_LO = 0;
    localparam int DATA_AVG_W  = 12;
    localparam int DATA_SEQ_LO = 16;
    localparam int DATA_SEQ_W  = 8;

    function automatic logic [31:0] pack_data(input logic [DATA_SEQ_W-1:0] seq,
                                              input logic [DATA_AVG_W-1:0] avg);
        logic [31:0] w;
        w = '0;
        w[DATA_SEQ_LO +: DATA_SEQ_W] = seq;
        w[DATA_AVG_LO +: DATA_AVG_W] = avg;
        return w;
    endfunction

endpackage

// File: rtl/edge_det.sv
// Registered rising-edge detector: o_rise is a one-cycle pulse the cycle
// after i_sig is first seen high.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;
    logic r_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_prev <= i_sig;
            r_rise <= i_sig & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/xadc_seq_ctrl.sv
// XADC conversion sequencer: issues CONVST, averages 1/2/4/8 samples,
// writes the result word and updates sticky new/flag/error status.
//
// state | meaning
// IDLE  | waiting for start rising edge
// CONV  | one-cycle CONVST pulse, timeout counter loaded
// WAIT  | waiting for EOC or timeout
// WRITE | result word valid, data register write strobe
// STAT  | status visible, control register write strobe
module xadc_seq_ctrl
    import xadc_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1023,
    parameter int ADC_W       = 12,
    parameter int SEQ_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_ctrl,
    input  logic [ADC_W-1:0]  i_adc_data,
    input  logic              i_adc_eoc,
    output logic              o_convst,
    output logic [31:0]       o_data,
    output logic              o_wr_data,
    output logic              o_wr_ctrl,
    output logic              o_new,
    output logic              o_flag,
    output logic              o_err,
    output logic              o_busy
);

    localparam int ACC_W = ADC_W + 3;
    localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    // Loaded with TIMEOUT_CYC-2 so that o_err appears TIMEOUT_CYC cycles after CONVST.
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 2);

    state_t             r_state;
    state_t             w_next;

    logic               w_start_evt;
    logic               w_ack_evt;

    logic [1:0]         r_avg_sel;
    logic [3:0]         r_thr;
    logic               r_cont;

    logic [ACC_W-1:0]   r_acc;
    logic [2:0]         r_cnt;
    logic [TMO_W-1:0]   r_tmo;
    logic [SEQ_W-1:0]   r_seq;
    logic [31:0]        r_data;
    logic               r_new;
    logic               r_flag;
    logic               r_err;
    logic               r_wr_ctrl;

    logic [ACC_W-1:0]   w_acc_sum;
    logic [DATA_AVG_W-1:0] w_avg;
    logic [SEQ_W-1:0]   w_seq_nxt;
    logic [3:0]         w_n;
    logic               w_last;
    logic               w_eoc_take;
    logic               w_tmo_exp;
    logic               w_batch_start;
    logic               w_flag_hit;
    logic               w_ctrl_unused;

    assign w_ctrl_unused = ^i_ctrl[31:CTRL_THR_HI+1];

    edge_det u_start_det (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (i_ctrl[CTRL_START]),
        .o_rise (w_start_evt)
    );

    edge_det u_ack_det (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (i_ctrl[CTRL_ACK]),
        .o_rise (w_ack_evt)
    );

    assign w_batch_start = (r_state == ST_IDLE) && w_start_evt;
    assign w_eoc_take    = (r_state == ST_WAIT) && i_adc_eoc;
    assign w_tmo_exp     = (r_state == ST_WAIT) && !i_adc_eoc && (r_tmo == '0);
    assign w_n           = 4'd1 << r_avg_sel;
    assign w_last        = (({1'b0, r_cnt} + 4'd1) == w_n);
    assign w_acc_sum     = r_acc + ACC_W'(i_adc_data);
    assign w_avg         = DATA_AVG_W'(w_acc_sum >> r_avg_sel);
    assign w_seq_nxt     = r_seq + SEQ_W'(1);
    assign w_flag_hit    = (r_data[DATA_AVG_LO +: DATA_AVG_W] >= {r_thr, 8'h00});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_start_evt) w_next = ST_CONV;
            ST_CONV:  w_next = ST_WAIT;
            ST_WAIT: begin
                if (i_adc_eoc) begin
                    w_next = w_last ? ST_WRITE : ST_CONV;
                end else if (r_tmo == '0) begin
                    w_next = ST_IDLE;
                end
            end
            ST_WRITE: w_next = ST_STAT;
            ST_STAT:  w_next = (r_cont && i_ctrl[CTRL_CONT]) ? ST_CONV : ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_convst  = 1'b0;
        o_wr_data = 1'b0;
        o_busy    = 1'b1;
        unique case (r_state)
            ST_IDLE:  o_busy    = 1'b0;
            ST_CONV:  o_convst  = 1'b1;
            ST_WRITE: o_wr_data = 1'b1;
            default:  o_busy    = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_avg_sel <= '0;
            r_thr     <= '0;
            r_cont    <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_tmo     <= '0;
            r_seq     <= '0;
            r_data    <= '0;
        end else begin
            if (w_batch_start) begin
                r_avg_sel <= i_ctrl[CTRL_AVG_HI:CTRL_AVG_LO];
                r_thr     <= i_ctrl[CTRL_THR_HI:CTRL_THR_LO];
                r_cont    <= i_ctrl[CTRL_CONT];
                r_acc     <= '0;
                r_cnt     <= '0;
            end else if (r_state == ST_STAT) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_eoc_take) begin
                r_acc <= w_acc_sum;
                r_cnt <= r_cnt + 3'd1;
            end

            if (r_state == ST_CONV) begin
                r_tmo <= TMO_LOAD;
            end else if ((r_state == ST_WAIT) && (r_tmo != '0)) begin
                r_tmo <= r_tmo - TMO_W'(1);
            end

            // Result word is registered on the final EOC so it is stable during WRITE.
            if (w_eoc_take && w_last) begin
                r_data <= pack_data(w_seq_nxt[DATA_SEQ_W-1:0], w_avg);
                r_seq  <= w_seq_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_new     <= 1'b0;
            r_flag    <= 1'b0;
            r_err     <= 1'b0;
            r_wr_ctrl <= 1'b0;
        end else begin
            r_wr_ctrl <= (r_state == ST_WRITE) || w_tmo_exp || w_ack_evt;

            if (w_batch_start) begin
                r_err <= 1'b0;
            end else if (w_tmo_exp) begin
                r_err <= 1'b1;
            end

            // A new result takes priority over a coincident acknowledge.
            if (r_state == ST_WRITE) begin
                r_new  <= 1'b1;
                r_flag <= w_flag_hit || (r_flag && !w_ack_evt);
            end else if (w_ack_evt) begin
                r_new  <= 1'b0;
                r_flag <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_wr_ctrl = r_wr_ctrl;
    assign o_new     = r_new;
    assign o_flag    = r_flag;
    assign o_err     = r_err;

endmodule

// File: tb/tb_xadc_seq_ctrl.sv
// Directed bench for xadc_seq_ctrl with an automatic EOC responder.
`timescale 1ns/1ps
module tb_xadc_seq_ctrl;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_ctrl;
    logic [11:0] adc_data;
    logic        adc_eoc;
    logic        o_convst, o_wr_data, o_wr_ctrl, o_new, o_flag, o_err, o_busy;
    logic [31:0] o_data;

    logic        resp_eoc;
    logic [11:0] resp_data;
    logic        inj_eoc;
    logic [11:0] inj_data;
    logic        resp_en;
    int          resp_dly;
    logic [11:0] resp_base;
    logic [11:0] resp_step;
    int          resp_cnt = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_convst = 0;
    int n_wrd    = 0;
    int n_wrc    = 0;

    int          s_conv, s_wrd, s_wrc;
    int          lat_a, lat_b, cnt;
    logic        bit_a;
    logic [31:0] got;

    always #5 clk = ~clk;

    assign adc_eoc  = resp_eoc | inj_eoc;
    assign adc_data = inj_eoc ? inj_data : resp_data;

    xadc_seq_ctrl #(
        .TIMEOUT_CYC (TMO),
        .ADC_W       (12),
        .SEQ_W       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_ctrl     (i_ctrl),
        .i_adc_data (adc_data),
        .i_adc_eoc  (adc_eoc),
        .o_convst   (o_convst),
        .o_data     (o_data),
        .o_wr_data  (o_wr_data),
        .o_wr_ctrl  (o_wr_ctrl),
        .o_new      (o_new),
        .o_flag     (o_flag),
        .o_err      (o_err),
        .o_busy     (o_busy)
    );

    always @(posedge clk) begin
        if (o_convst)  n_convst++;
        if (o_wr_data) n_wrd++;
        if (o_wr_ctrl) n_wrc++;
    end

    // EOC responder: answers each CONVST resp_dly cycles later.
    initial begin
        resp_eoc  = 1'b0;
        resp_data = '0;
        forever begin
            @(negedge clk);
            resp_eoc = 1'b0;
            if (resp_en && o_convst) begin
                repeat (resp_dly) @(negedge clk);
                resp_eoc  = 1'b1;
                resp_data = resp_base + 12'(resp_step * resp_cnt);
                resp_cnt++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
        end
    endtask

    task automatic set_resp(input logic en, input int dly, input logic [11:0] first,
                            input logic [11:0] step);
        resp_en   = en;
        resp_dly  = dly;
        resp_step = step;
        resp_base = first - 12'(step * resp_cnt);
    endtask

    task automatic start(input logic [31:0] cfg);
        i_ctrl = cfg & ~32'h1;
        @(negedge clk);
        i_ctrl = cfg | 32'h1;
        @(negedge clk);
    endtask

    task automatic wait_convst(input string tag);
        int n = 0;
        while (!o_convst && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(o_convst), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n = 0;
        while (o_busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(o_busy), 32'd0);
    endtask

    task automatic do_ack();
        i_ctrl = i_ctrl | 32'h10;
        repeat (3) @(negedge clk);
        i_ctrl = i_ctrl & ~32'h10;
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        i_ctrl   = '0;
        inj_eoc  = 1'b0;
        inj_data = '0;
        set_resp(1'b0, 1, 12'h0, 12'h0);
        repeat (3) @(negedge clk);
        chk("rst_data", o_data, 32'h0);
        chk("rst_status", 32'({o_new, o_flag, o_err, o_busy, o_convst, o_wr_data, o_wr_ctrl}), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single sample, latency and threshold above
        set_resp(1'b1, 5, 12'hABC, 12'h0);
        s_wrd = n_wrd; s_wrc = n_wrc;
        start(32'h140);
        wait_convst("t1_convst");
        lat_a = -1; lat_b = -1; got = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (o_wr_data && lat_a < 0) begin lat_a = i; got = o_data; end
            if (o_wr_ctrl && lat_b < 0) lat_b = i;
        end
        chk("t1_wr_data_lat", 32'(lat_a), 32'd6);
        chk("t1_wr_ctrl_lat", 32'(lat_b), 32'd7);
        chk("t1_data_at_strobe", got, 32'h0001_0ABC);
        chk("t1_wrd_pulses", 32'(n_wrd - s_wrd), 32'd1);
        chk("t1_wrc_pulses", 32'(n_wrc - s_wrc), 32'd1);
        chk("t1_new_flag_err_busy", 32'({o_new, o_flag, o_err, o_busy}), 32'b1100);

        // four-sample average, start retrigger while busy ignored
        set_resp(1'b1, 3, 12'd100, 12'd1);
        s_conv = n_convst; s_wrd = n_wrd;
        start(32'h008);
        wait_convst("t2_convst");
        repeat (2) @(negedge clk);
        i_ctrl = 32'h008;
        @(negedge clk);
        i_ctrl = 32'h009;
        wait_idle("t2_idle", 60);
        repeat (3) @(negedge clk);
        chk("t2_convst_cnt", 32'(n_convst - s_conv), 32'd4);
        chk("t2_wrd_pulses", 32'(n_wrd - s_wrd), 32'd1);
        chk("t2_data", o_data, 32'h0002_0065);
        chk("t2_flag_thr0", 32'(o_flag), 32'd1);

        // acknowledge clears status
        s_wrc = n_wrc;
        do_ack();
        chk("t3_ack_new_flag", 32'({o_new, o_flag}), 32'd0);
        chk("t3_ack_wrc", 32'(n_wrc - s_wrc), 32'd1);

        // EOC timeout
        set_resp(1'b0, 1, 12'h0, 12'h0);
        s_wrd = n_wrd;
        start(32'h1E0);
        wait_convst("t4_convst");
        lat_a = -1; lat_b = -1; bit_a = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (o_err && lat_a < 0) lat_a = i;
            if (o_wr_ctrl && lat_b < 0) lat_b = i;
            if (i == TMO) bit_a = o_busy;
        end
        chk("t4_err_lat", 32'(lat_a), 32'(TMO));
        chk("t4_wrc_lat", 32'(lat_b), 32'(TMO));
        chk("t4_busy_at_tmo", 32'(bit_a), 32'd0);
        chk("t4_no_wr_data", 32'(n_wrd - s_wrd), 32'd0);
        chk("t4_err_new", 32'({o_err, o_new}), 32'b10);

        // threshold equality, sticky flag, 8-sample truncation
        set_resp(1'b1, 2, 12'h100, 12'h0);
        start(32'h020);
        wait_convst("t5a_convst");
        wait_idle("t5a_idle", 40);
        chk("t5a_data", o_data, 32'h0003_0100);
        chk("t5a_flag_eq_thr", 32'({o_new, o_flag, o_err}), 32'b110);
        set_resp(1'b1, 2, 12'h0FF, 12'h0);
        start(32'h020);
        wait_convst("t5b_convst");
        wait_idle("t5b_idle", 40);
        chk("t5b_data", o_data, 32'h0004_00FF);
        chk("t5b_flag_sticky", 32'(o_flag), 32'd1);
        set_resp(1'b1, 2, 12'd10, 12'd1);
        s_conv = n_convst;
        start(32'h1EC);
        wait_convst("t5c_convst");
        wait_idle("t5c_idle", 80);
        @(negedge clk);
        chk("t5c_data_trunc", o_data, 32'h0005_000D);
        chk("t5c_convst_cnt", 32'(n_convst - s_conv), 32'd8);
        do_ack();

        // continuous mode, sequence wrap, stop mid-run
        set_resp(1'b1, 1, 12'h123, 12'h0);
        start(32'h1E2);
        wait_convst("t6_convst");
        cnt = 0; bit_a = 1'b0; got = '1;
        for (int i = 0; i < 2000 && !bit_a; i++) begin
            @(negedge clk);
            if (o_wr_data) begin
                cnt++;
                if (cnt == 251) begin
                    bit_a = 1'b1;
                    got = o_data;
                end
            end
        end
        chk("t6_wrap_reached", 32'(bit_a), 32'd1);
        chk("t6_wrap_data", got, 32'h0000_0123);
        wait_convst("t6_next_convst");
        i_ctrl = 32'h1E1;
        s_wrd = n_wrd;
        wait_idle("t6_stop_idle", 20);
        repeat (2) @(negedge clk);
        chk("t6_last_batch", 32'(n_wrd - s_wrd), 32'd1);
        chk("t6_last_data", o_data, 32'h0001_0123);
        chk("t6_new_flag", 32'({o_new, o_flag}), 32'b10);

        // ack coincident with status set, then a later ack
        do_ack();
        chk("t7_pre_new", 32'(o_new), 32'd0);
        set_resp(1'b1, 4, 12'h555, 12'h0);
        start(32'h000);
        wait_convst("t7_convst");
        repeat (4) @(negedge clk);
        i_ctrl = 32'h11;
        @(negedge clk);
        chk("t7_write_cycle", 32'(o_wr_data), 32'd1);
        @(negedge clk);
        chk("t7_set_wins", 32'({o_new, o_flag}), 32'b11);
        @(negedge clk);
        chk("t7_new_held", 32'(o_new), 32'd1);
        i_ctrl = 32'h01;
        @(negedge clk);
        i_ctrl = 32'h11;
        repeat (3) @(negedge clk);
        chk("t7_ack_clears", 32'({o_new, o_flag}), 32'd0);
        chk("t7_data", o_data, 32'h0002_0555);

        // reset during WAIT, stray EOC, fresh batch
        set_resp(1'b0, 1, 12'h0, 12'h0);
        start(32'h000);
        wait_convst("t8_convst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        i_ctrl = '0;
        repeat (2) @(negedge clk);
        chk("t8_rst_data", o_data, 32'h0);
        chk("t8_rst_status", 32'({o_new, o_flag, o_err, o_busy, o_convst, o_wr_data, o_wr_ctrl}), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        s_wrd = n_wrd; s_wrc = n_wrc;
        inj_data = 12'hFFF;
        inj_eoc  = 1'b1;
        @(negedge clk);
        inj_eoc  = 1'b0;
        repeat (3) @(negedge clk);
        chk("t8_stray_busy", 32'(o_busy), 32'd0);
        chk("t8_stray_strobes", 32'((n_wrd - s_wrd) + (n_wrc - s_wrc)), 32'd0);
        set_resp(1'b1, 2, 12'h2A5, 12'h0);
        start(32'h000);
        wait_convst("t8_convst2");
        wait_idle("t8_idle", 40);
        chk("t8_fresh_data", o_data, 32'h0001_02A5);
        chk("t8_fresh_new", 32'(o_new), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xadc_seq_ctrl.md
Name: xadc_seq_ctrl

Overview:
Sequencer for the XADC sampling datapath. It starts conversions on command from the control register word and collects 1/2/4/8 samples per XADC end-of-conversion handshake. It averages the samples, writes the result to the data register with a one-cycle write strobe, and then updates the control register's new/flag/error status. It sits between the XADC wrapper, the data register and the control register, replacing ad-hoc write-enable generation.

Parameters:
TIMEOUT_CYC, 1023, clock cycles to wait for EOC after CONVST before aborting (minimum 2)
ADC_W, 12, XADC sample width
SEQ_W, 8, width of result sequence counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
i_ctrl  in  32  control register word: [0] start, [1] continuous, [3:2] avg_sel (n = 2^avg_sel samples), [4] ack, [8:5] thr_hi; [31:9] ignored
i_adc_data  in  ADC_W  XADC conversion result, valid in the EOC cycle
i_adc_eoc  in  1  XADC end-of-conversion, one-cycle pulse
o_convst  out  1  one-cycle conversion start pulse to XADC
o_data  out  32  {8'h00, seq[7:0], 4'h0, avg[11:0]}
o_wr_data  out  1  one-cycle write strobe to data register
o_wr_ctrl  out  1  one-cycle write strobe to control register (status update)
o_new  out  1  result available, sticky
o_flag  out  1  threshold exceeded, sticky
o_err  out  1  EOC timeout occurred, sticky
o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any state): state=IDLE; o_data=0; seq=0; acc=0; all strobes and status outputs 0; edge-detect registers 0.
- start_evt = rising edge of i_ctrl[0], registered (prev sampled each clk); ack_evt = rising edge of i_ctrl[4].
- avg_sel, thr_hi and continuous are latched on entry to CONV from IDLE; changes mid-batch have no effect until the next batch.
- IDLE: on start_evt -> CONV; clear acc and sample counter; clear o_err.
- CONV: o_convst=1 for exactly this cycle; load timeout counter; -> WAIT.
- WAIT: on i_adc_eoc: acc += i_adc_data (15-bit acc, no overflow possible at n<=8), cnt++. If cnt+1 == n -> WRITE, else -> CONV. If the timeout counter expires without EOC: o_err=1, o_wr_ctrl=1 next cycle, -> IDLE. EOC in any other state is ignored.
- WRITE: avg = acc >> avg_sel (truncating); o_data updated; o_wr_data=1 this cycle; seq increments and wraps 255->0; -> STAT.
- STAT: o_new=1; o_flag set if avg >= {thr_hi, 8'h00} (flag not cleared by a below-threshold result); o_wr_ctrl=1 this cycle. If continuous latched and i_ctrl[1] still 1 -> CONV (acc and cnt cleared), else -> IDLE.
- Latency (n=1): CONVST at cycle t; EOC at t+k; o_wr_data at t+k+1; o_wr_ctrl at t+k+2.
- ack_evt in any state: clears o_new and o_flag, and pulses o_wr_ctrl the next cycle. If ack_evt and STAT set coincide, set wins.
- start_evt while busy: ignored. Clearing i_ctrl[1] mid-batch completes the current batch, then -> IDLE.
- Reset mid-conversion: the next start begins a fresh batch; a stale EOC arriving in IDLE is ignored.
- thr_hi=0: flag set on every result.

Decomposition:
- Shared package xadc_pkg: state encoding (IDLE, CONV, WAIT, WRITE, STAT), control bit indices (CTRL_START=0, CTRL_CONT=1, CTRL_AVG=3:2, CTRL_ACK=4, CTRL_THR=8:5), data word field positions.
- One natural sub-module: edge_det (registered rising-edge detector), instantiated for start and ack.
- Accumulator and timeout counter stay inline.

Test Plan:
- avg_sel=0, start 0->1, EOC 5 cycles after CONVST with data 12'hABC -> o_data=32'h0001_0ABC, o_wr_data one pulse, o_new=1, o_flag=1 at thr_hi=4'hA, one o_wr_ctrl pulse.
- avg_sel=2, samples 100,101,102,103 -> four CONVST pulses, avg=101 (12'h065), single o_wr_data pulse after the 4th EOC.
- No EOC after CONVST with TIMEOUT_CYC=16 -> o_err=1 at cycle 16 after CONVST, o_wr_ctrl pulse, state IDLE, o_wr_data never asserted.
- Continuous mode, 256 results -> seq wraps to 8'h00 in o_data[23:16]; clearing i_ctrl[1] mid-batch -> that batch finishes, then o_busy=0.
- ack rising edge in the same cycle as STAT -> o_new stays 1; ack on the following cycle -> o_new=0, o_flag=0.
- Assert rst during WAIT, then inject a stray EOC -> all outputs 0, no strobes; the next start produces a normal result with seq=1.
